gen_sequencer: RTL

GEN_SEQUENCER -- requirements
Module: gen_sequencer

---
 rtl/life_pkg.sv | 18 +
 rtl/gen_sequencer_decoder_top.sv | 26 ++
 rtl/gen_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared types and sizing for the 8x8 toroidal Life generation sequencer.
package life_pkg;

    localparam int unsigned ROWS   = 8;
    localparam int unsigned COLS   = 8;
    localparam int unsigned ROW_AW = 3;
    localparam int unsigned GEN_W  = 8;

    typedef logic [COLS-1:0] row_t;
    typedef row_t [ROWS-1:0] board_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMMIT  = 2'd2
    } gen_state_t;

endpackage

// File: rtl/gen_sequencer_decoder_top.sv
// Next-state datapath: one row of Life evaluated from itself and its two
// vertical neighbours, with columns wrapping around.
module decoder_top
    import life_pkg::*;
(
    input  logic [COLS-1:0] row_a,
    input  logic [COLS-1:0] row_in,
    input  logic [COLS-1:0] row_b,
    output logic [COLS-1:0] row_out
);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int unsigned CL = (c + COLS - 1) % COLS;
        localparam int unsigned CR = (c + 1) % COLS;

        logic [3:0] n;

        assign n = 4'(row_a[CL])  + 4'(row_a[c])  + 4'(row_a[CR])
                 + 4'(row_in[CL])                 + 4'(row_in[CR])
                 + 4'(row_b[CL])  + 4'(row_b[c])  + 4'(row_b[CR]);

        // Birth on exactly three neighbours, survival on two or three.
        assign row_out[c] = (n == 4'd3) || (row_in[c] && (n == 4'd2));
    end

endmodule

// File: rtl/gen_sequencer.sv
// Steps an 8x8 toroidal Life board one row per cycle into a shadow buffer,
// then commits the whole generation at once.
module gen_sequencer
    import life_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       auto_run,
    input  logic       tick,
    input  logic       load_en,
    input  logic [2:0] load_addr,
    input  logic [7:0] load_data,
    input  logic       clear,
    input  logic [2:0] disp_addr,
    output logic [7:0] disp_row,
    output logic       busy,
    output logic       done,
    output logic       stable,
    output logic       load_rej,
    output logic [7:0] gen_count
);

    gen_state_t        state_q, state_d;
    logic [ROW_AW-1:0] r_q, r_d;
    logic [ROW_AW-1:0] r_up, r_dn;
    board_t            cur_q, cur_d;
    board_t            nxt_q, nxt_d;
    logic [GEN_W-1:0]  gen_q, gen_d;
    logic              stable_q, stable_d;
    logic              done_q, done_d;
    logic              rej_q, rej_d;
    row_t              row_new;
    logic              step_req;

    assign r_up     = r_q - ROW_AW'(1);
    assign r_dn     = r_q + ROW_AW'(1);
    assign step_req = start || (auto_run && tick);

    decoder_top u_decoder (
        .row_a   (cur_q[r_up]),
        .row_in  (cur_q[r_q]),
        .row_b   (cur_q[r_dn]),
        .row_out (row_new)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            r_q      <= '0;
            cur_q    <= '0;
            nxt_q    <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
            done_q   <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            cur_q    <= cur_d;
            nxt_q    <= nxt_d;
            gen_q    <= gen_d;
            stable_q <= stable_d;
            done_q   <= done_d;
            rej_q    <= rej_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        cur_d    = cur_q;
        nxt_d    = nxt_q;
        gen_d    = gen_q;
        stable_d = stable_q;
        done_d   = 1'b0;
        rej_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Only the highest-priority request acts; the rest are dropped.
                if (clear) begin
                    cur_d    = '0;
                    gen_d    = '0;
                    stable_d = 1'b0;
                end else if (load_en) begin
                    cur_d[load_addr] = load_data;
                end else if (step_req) begin
                    state_d = COMPUTE;
                    r_d     = '0;
                end
            end
            COMPUTE: begin
                rej_d        = load_en || clear;
                nxt_d[r_q]   = row_new;
                r_d          = r_q + ROW_AW'(1);
                if (r_q == ROW_AW'(ROWS - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                rej_d    = load_en || clear;
                cur_d    = nxt_q;
                gen_d    = gen_q + GEN_W'(1);
                stable_d = (nxt_q == cur_q);
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign disp_row  = cur_q[disp_addr];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign stable    = stable_q;
    assign load_rej  = rej_q;
    assign gen_count = gen_q;

endmodule
